// File: rtl/conv_ifmap_addr_gen.sv
`default_nettype none
// conv_ifmap_addr_gen: sweeps convolution windows and emits input-feature-map word addresses.
// Optional zero-padding border enabled by defining CONV_IFMAP_PAD_EN. Rev 1.0
module conv_ifmap_addr_gen #(
  parameter int IN_W   = 8,
  parameter int IN_H   = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CH     = 1,
  parameter int PASSES = 1,
  parameter int PAD    = 0,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              addr_ready,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              pad,
  output logic              last,
  output logic              busy,
  output logic              done
);

`ifdef CONV_IFMAP_PAD_EN
  localparam int PADE = PAD;
`else
  localparam int PADE = PAD * 0;
`endif

  localparam int OW  = (IN_W + 2*PADE - K) / STRIDE + 1;
  localparam int OH  = (IN_H + 2*PADE - K) / STRIDE + 1;
  localparam int KW  = (K      > 1) ? $clog2(K)      : 1;
  localparam int CW  = (CH     > 1) ? $clog2(CH)     : 1;
  localparam int OXW = (OW     > 1) ? $clog2(OW)     : 1;
  localparam int OYW = (OH     > 1) ? $clog2(OH)     : 1;
  localparam int PW  = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     kx_q, kx_d, ky_q, ky_d;
  logic [CW-1:0]     c_q, c_d;
  logic [OXW-1:0]    ox_q, ox_d;
  logic [OYW-1:0]    oy_q, oy_d;
  logic [PW-1:0]     p_q, p_d;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;
  logic              load;

  logic [ADDR_W-1:0] addr_calc;
  logic              last_calc;
  logic              pad_calc;
  int                x_pos, y_pos, lin_addr;

  // Next-state and loop-nest stepping; a handshake on the final beat ends the sweep.
  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    c_d     = c_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    p_d     = p_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          kx_d = '0; ky_d = '0; c_d = '0; ox_d = '0; oy_d = '0; p_d = '0;
          load = 1'b1;
        end
      end
      RUN: begin
        if (addr_ready) begin
          if (last_q) begin
            state_d = DONE;
            kx_d = '0; ky_d = '0; c_d = '0; ox_d = '0; oy_d = '0; p_d = '0;
          end else begin
            load = 1'b1;
            if (kx_q != KW'(K-1)) begin
              kx_d = kx_q + 1'b1;
            end else begin
              kx_d = '0;
              if (ky_q != KW'(K-1)) begin
                ky_d = ky_q + 1'b1;
              end else begin
                ky_d = '0;
                if (c_q != CW'(CH-1)) begin
                  c_d = c_q + 1'b1;
                end else begin
                  c_d = '0;
                  if (ox_q != OXW'(OW-1)) begin
                    ox_d = ox_q + 1'b1;
                  end else begin
                    ox_d = '0;
                    if (oy_q != OYW'(OH-1)) begin
                      oy_d = oy_q + 1'b1;
                    end else begin
                      oy_d = '0;
                      p_d  = p_q + 1'b1;
                    end
                  end
                end
              end
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address of the beat that the next counter values describe; registered on load.
  always_comb begin
    x_pos     = int'(ox_d) * STRIDE + int'(kx_d) - PADE;
    y_pos     = int'(oy_d) * STRIDE + int'(ky_d) - PADE;
    lin_addr  = int'(c_d) * (IN_W * IN_H) + y_pos * IN_W + x_pos;
    addr_calc = ADDR_W'(lin_addr);
    last_calc = (kx_d == KW'(K-1))  && (ky_d == KW'(K-1)) && (c_d == CW'(CH-1)) &&
                (ox_d == OXW'(OW-1)) && (oy_d == OYW'(OH-1)) && (p_d == PW'(PASSES-1));
`ifdef CONV_IFMAP_PAD_EN
    pad_calc  = (x_pos < 0) || (x_pos >= IN_W) || (y_pos < 0) || (y_pos >= IN_H);
    if (pad_calc) addr_calc = '0;
`else
    pad_calc  = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      c_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      p_q     <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      c_q     <= c_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      p_q     <= p_d;
      if (load) begin
        addr_q <= addr_calc;
        last_q <= last_calc;
      end
    end
  end

`ifdef CONV_IFMAP_PAD_EN
  logic pad_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pad_q <= 1'b0;
    else if (load) pad_q <= pad_calc;
  end
  assign pad = pad_q;
`else
  assign pad = 1'b0;
`endif

  assign addr_valid = (state_q == RUN);
  assign busy       = (state_q == RUN) || (state_q == DONE);
  assign done       = (state_q == DONE);
  assign addr       = addr_q;
  assign last       = last_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_ifmap_addr_gen.sv
`default_nettype none
// tb_conv_ifmap_addr_gen: several configurations checked against a loop-nest reference model.
module tb_conv_ifmap_addr_gen;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_s [4];
  logic              ready_s [4];
  logic              valid_s [4];
  logic [ADDR_W-1:0] addr_s  [4];
  logic              pad_s   [4];
  logic              last_s  [4];
  logic              busy_s  [4];
  logic              done_s  [4];

  int n_err    = 0;
  int n_checks = 0;

  int exp_addr [$];
  int exp_pad  [$];
  int exp_last [$];
  int obs_addr [$];
  int obs_pad  [$];

  always #5 clk = ~clk;

  conv_ifmap_addr_gen #(.IN_W(4), .IN_H(4), .K(3), .STRIDE(1), .CH(1), .PASSES(1), .ADDR_W(ADDR_W)) u_a (
    .clk(clk), .reset(reset), .start(start_s[0]), .addr_ready(ready_s[0]),
    .addr_valid(valid_s[0]), .addr(addr_s[0]), .pad(pad_s[0]), .last(last_s[0]),
    .busy(busy_s[0]), .done(done_s[0]));

  conv_ifmap_addr_gen #(.IN_W(5), .IN_H(5), .K(3), .STRIDE(2), .CH(1), .PASSES(1), .ADDR_W(ADDR_W)) u_b (
    .clk(clk), .reset(reset), .start(start_s[1]), .addr_ready(ready_s[1]),
    .addr_valid(valid_s[1]), .addr(addr_s[1]), .pad(pad_s[1]), .last(last_s[1]),
    .busy(busy_s[1]), .done(done_s[1]));

  conv_ifmap_addr_gen #(.IN_W(4), .IN_H(4), .K(3), .STRIDE(1), .CH(2), .PASSES(2), .ADDR_W(ADDR_W)) u_c (
    .clk(clk), .reset(reset), .start(start_s[2]), .addr_ready(ready_s[2]),
    .addr_valid(valid_s[2]), .addr(addr_s[2]), .pad(pad_s[2]), .last(last_s[2]),
    .busy(busy_s[2]), .done(done_s[2]));

`ifdef CONV_IFMAP_PAD_EN
  conv_ifmap_addr_gen #(.IN_W(3), .IN_H(3), .K(3), .STRIDE(1), .CH(1), .PASSES(1), .PAD(1), .ADDR_W(ADDR_W)) u_d (
    .clk(clk), .reset(reset), .start(start_s[3]), .addr_ready(ready_s[3]),
    .addr_valid(valid_s[3]), .addr(addr_s[3]), .pad(pad_s[3]), .last(last_s[3]),
    .busy(busy_s[3]), .done(done_s[3]));
`else
  assign valid_s[3] = 1'b0;
  assign addr_s[3]  = '0;
  assign pad_s[3]   = 1'b0;
  assign last_s[3]  = 1'b0;
  assign busy_s[3]  = 1'b0;
  assign done_s[3]  = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference: the sweep written directly as the nested loops, coordinates and bounds rule.
  task automatic build_model(input int in_w, input int in_h, input int k, input int stride,
                             input int ch, input int passes, input int pd);
    int ow, oh, x, y, total, ispad;
    exp_addr.delete(); exp_pad.delete(); exp_last.delete();
    ow = (in_w + 2*pd - k) / stride + 1;
    oh = (in_h + 2*pd - k) / stride + 1;
    for (int p = 0; p < passes; p++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++)
          for (int c = 0; c < ch; c++)
            for (int ky = 0; ky < k; ky++)
              for (int kx = 0; kx < k; kx++) begin
                x = ox*stride + kx - pd;
                y = oy*stride + ky - pd;
                ispad = (x < 0 || x >= in_w || y < 0 || y >= in_h) ? 1 : 0;
                exp_addr.push_back(ispad ? 0 : ((c*in_w*in_h + y*in_w + x) % (1 << ADDR_W)));
                exp_pad.push_back(ispad);
                exp_last.push_back(0);
              end
    total = exp_last.size();
    exp_last[total-1] = 1;
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles on the second beat.
  task automatic run_sweep(input int idx, input int mode, input int restart_at, input int abort_at);
    int beat, cyc, stall, limit, nbeats;
    logic rdy;
    nbeats = exp_addr.size();
    obs_addr.delete(); obs_pad.delete();
    @(negedge clk);
    chk("idle_valid", valid_s[idx], 0);
    chk("idle_busy", busy_s[idx], 0);
    start_s[idx] = 1'b1;
    ready_s[idx] = 1'b1;
    @(negedge clk);
    start_s[idx] = 1'b0;
    beat = 0; cyc = 0; stall = 0; limit = nbeats*8 + 100;
    while (beat < nbeats && cyc < limit) begin
      if (abort_at >= 0 && beat == abort_at) begin
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", valid_s[idx], 0);
        chk("rst_addr", addr_s[idx], 0);
        chk("rst_pad", pad_s[idx], 0);
        chk("rst_last", last_s[idx], 0);
        chk("rst_busy", busy_s[idx], 0);
        chk("rst_done", done_s[idx], 0);
        @(negedge clk);
        reset = 1'b0;
        start_s[idx] = 1'b0;
        ready_s[idx] = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("post_rst_valid", valid_s[idx], 0);
        end
        return;
      end
      chk("valid", valid_s[idx], 1);
      chk("addr", addr_s[idx], exp_addr[beat]);
      chk("pad", pad_s[idx], exp_pad[beat]);
      chk("last", last_s[idx], exp_last[beat]);
      case (mode)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2:       rdy = !(beat == 1 && stall < 3);
        default: rdy = 1'b1;
      endcase
      if (!rdy) stall++;
      ready_s[idx] = rdy;
      start_s[idx] = (beat == restart_at);
      if (rdy) begin
        obs_addr.push_back(int'(addr_s[idx]));
        obs_pad.push_back(int'(pad_s[idx]));
        beat++;
      end
      cyc++;
      @(negedge clk);
    end
    start_s[idx] = 1'b0;
    if (beat < nbeats) begin
      chk("timeout_beats", beat, nbeats);
    end else begin
      if (mode == 0) chk("no_bubbles", cyc, nbeats);
      chk("done_pulse", done_s[idx], 1);
      chk("done_busy", busy_s[idx], 1);
      chk("done_valid", valid_s[idx], 0);
      start_s[idx] = 1'b1;
      @(negedge clk);
      start_s[idx] = 1'b0;
      chk("done_clear", done_s[idx], 0);
      chk("idle_busy_after", busy_s[idx], 0);
      @(negedge clk);
      chk("start_in_done_ignored", valid_s[idx], 0);
    end
    ready_s[idx] = 1'b0;
  endtask

  initial begin
    int exp9 [9];
    exp9 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0;
      ready_s[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset_valid", valid_s[0], 0);
    chk("reset_addr", addr_s[0], 0);
    chk("reset_last", last_s[0], 0);
    chk("reset_busy", busy_s[0], 0);
    chk("reset_done", done_s[0], 0);
    reset = 1'b0;

    // 4x4 map, 3x3 kernel
    build_model(4, 4, 3, 1, 1, 1, 0);
    run_sweep(0, 0, -1, -1);
    chk("a_len", obs_addr.size(), 36);
    for (int i = 0; i < 9; i++) chk("a_first9", obs_addr[i], exp9[i]);
    chk("a_final", obs_addr[35], 15);
    run_sweep(0, 2, -1, -1);
    run_sweep(0, 1, 7, -1);
    run_sweep(0, 0, -1, 20);
    run_sweep(0, 0, -1, -1);
    chk("a_after_reset_first", obs_addr[0], 0);
    chk("a_after_reset_len", obs_addr.size(), 36);

    // stride 2
    build_model(5, 5, 3, 2, 1, 1, 0);
    run_sweep(1, 1, 15, -1);
    chk("b_len", obs_addr.size(), 36);
    chk("b_beat10", obs_addr[9], 2);
    chk("b_beat19", obs_addr[18], 10);

    // two channels, two passes
    build_model(4, 4, 3, 1, 2, 2, 0);
    run_sweep(2, 1, 50, -1);
    chk("c_len", obs_addr.size(), 144);
    chk("c_beat10", obs_addr[9], 16);
    chk("c_beat73", obs_addr[72], 0);

`ifdef CONV_IFMAP_PAD_EN
    build_model(3, 3, 3, 1, 1, 1, 1);
    run_sweep(3, 1, -1, -1);
    chk("d_len", obs_addr.size(), 81);
    chk("d_beat1_pad", obs_pad[0], 1);
    chk("d_beat1_addr", obs_addr[0], 0);
    chk("d_beat5_pad", obs_pad[4], 0);
    chk("d_beat5_addr", obs_addr[4], 0);
    chk("d_beat9_pad", obs_pad[8], 0);
    chk("d_beat9_addr", obs_addr[8], 4);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
